// File: rtl/tournament_predict.sv
// Tournament branch predictor: per-PC local history + gshare global history,
// arbitrated by a PC-indexed choice table, with an F->D prediction register.
module tournament_predict #(
  parameter int BHT_DEPTH  = 10,
  parameter int LHR_WIDTH  = 6,
  parameter int GHR_WIDTH  = 8,
  parameter int CPHT_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flushD,
  input  logic        stallD,
  input  logic [31:0] pcF,
  input  logic [31:0] pcM,
  input  logic        branchD,
  input  logic        branchM,
  input  logic        actual_takeM,
  output logic        pred_takeD,
  output logic        pred_globalD
);

  localparam int BHT_N  = 1 << BHT_DEPTH;
  localparam int LPHT_N = 1 << LHR_WIDTH;
  localparam int GPHT_N = 1 << GHR_WIDTH;
  localparam int CPHT_N = 1 << CPHT_DEPTH;

  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
    if (up) begin
      sat_step = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    end else begin
      sat_step = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    end
  endfunction

  logic [LHR_WIDTH-1:0] bht  [BHT_N];
  logic [1:0]           lpht [LPHT_N];
  logic [1:0]           gpht [GPHT_N];
  logic [1:0]           cpht [CPHT_N];
  logic [GHR_WIDTH-1:0] ghr;

  logic [BHT_DEPTH-1:0]  bht_idx_f, bht_idx_m;
  logic [LHR_WIDTH-1:0]  lpht_idx_f, lpht_idx_m;
  logic [GHR_WIDTH-1:0]  gpht_idx_f, gpht_idx_m;
  logic [CPHT_DEPTH-1:0] cpht_idx_f, cpht_idx_m;
  logic [1:0]            lcnt_m, gcnt_m, ccnt_m, cnext_m;
  logic                  predL, predG, sel;
  logic                  predL_r, predG_r, sel_r;
  logic                  unused_pc;

  // Only the index fields of each PC feed the tables.
  assign unused_pc = ^{pcF, pcM};

  // F-stage lookup from the current (pre-edge) table contents.
  always_comb begin
    bht_idx_f  = pcF[BHT_DEPTH+1:2];
    lpht_idx_f = pcF[LHR_WIDTH+1:2] ^ bht[bht_idx_f];
    gpht_idx_f = pcF[GHR_WIDTH+1:2] ^ ghr;
    cpht_idx_f = pcF[CPHT_DEPTH+1:2];
    predL      = lpht[lpht_idx_f][1];
    predG      = gpht[gpht_idx_f][1];
    sel        = cpht[cpht_idx_f][1];
  end

  // M-stage update indices and next counter values.
  always_comb begin
    bht_idx_m  = pcM[BHT_DEPTH+1:2];
    lpht_idx_m = pcM[LHR_WIDTH+1:2] ^ bht[bht_idx_m];
    gpht_idx_m = pcM[GHR_WIDTH+1:2] ^ ghr;
    cpht_idx_m = pcM[CPHT_DEPTH+1:2];
    lcnt_m     = lpht[lpht_idx_m];
    gcnt_m     = gpht[gpht_idx_m];
    ccnt_m     = cpht[cpht_idx_m];
    // The chooser only learns when the two components disagreed.
    if (lcnt_m[1] != gcnt_m[1]) begin
      cnext_m = sat_step(ccnt_m, gcnt_m[1] == actual_takeM);
    end else begin
      cnext_m = ccnt_m;
    end
  end

  // Table and global-history state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++)  bht[i]  <= '0;
      for (int i = 0; i < LPHT_N; i++) lpht[i] <= 2'b10;
      for (int i = 0; i < GPHT_N; i++) gpht[i] <= 2'b10;
      for (int i = 0; i < CPHT_N; i++) cpht[i] <= 2'b01;
      ghr <= '0;
    end else if (branchM) begin
      lpht[lpht_idx_m] <= sat_step(lcnt_m, actual_takeM);
      gpht[gpht_idx_m] <= sat_step(gcnt_m, actual_takeM);
      cpht[cpht_idx_m] <= cnext_m;
      bht[bht_idx_m]   <= (bht[bht_idx_m] << 1'b1) | LHR_WIDTH'(actual_takeM);
      ghr              <= (ghr << 1'b1) | GHR_WIDTH'(actual_takeM);
    end
  end

  // F->D prediction register; flush wins over stall.
  always_ff @(posedge clk) begin
    if (rst || flushD) begin
      predL_r <= 1'b0;
      predG_r <= 1'b0;
      sel_r   <= 1'b0;
    end else if (!stallD) begin
      predL_r <= predL;
      predG_r <= predG;
      sel_r   <= sel;
    end
  end

  assign pred_globalD = branchD & sel_r;
  assign pred_takeD   = branchD & (sel_r ? predG_r : predL_r);

endmodule

// File: doc/tournament_predict.md
TOURNAMENT_PREDICT -- requirements
Module: tournament_predict

Interface
REQ-001 SHALL have parameter BHT_DEPTH, default 10: log2 of the local-history table entry count.
REQ-002 SHALL have parameter LHR_WIDTH, default 6: local history bits per entry and log2 of the local PHT size.
REQ-003 SHALL have parameter GHR_WIDTH, default 8: global history bits and log2 of the global PHT size.
REQ-004 SHALL have parameter CPHT_DEPTH, default 8: log2 of the choice table size.
REQ-005 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port flushD, input, 1 bit: clears the F->D prediction register.
REQ-008 SHALL have port stallD, input, 1 bit: holds the F->D prediction register.
REQ-009 SHALL have port pcF, input, 32 bits: fetch PC used for lookup.
REQ-010 SHALL have port pcM, input, 32 bits: PC of the branch resolving in M.
REQ-011 SHALL have port branchD, input, 1 bit: the instruction in D is a branch.
REQ-012 SHALL have port branchM, input, 1 bit: the instruction in M is a branch; enables update.
REQ-013 SHALL have port actual_takeM, input, 1 bit: resolved outcome of the branch in M.
REQ-014 SHALL have port pred_takeD, output, 1 bit: final taken prediction for D.
REQ-015 SHALL have port pred_globalD, output, 1 bit: 1 when the global predictor was selected for D.

Function
REQ-016 Counters SHALL be 2-bit binary saturating (00 SNT, 01 WNT, 10 WT, 11 ST); prediction SHALL be the MSB.
REQ-017 Local path SHALL work as follows: BHT index = pc[BHT_DEPTH+1:2]; local PHT index = pc[LHR_WIDTH+1:2] XOR BHT[entry].
REQ-018 Global path (gshare) SHALL work as follows: global PHT index = pc[GHR_WIDTH+1:2] XOR GHR.
REQ-019 Choice table SHALL be indexed by pc[CPHT_DEPTH+1:2]; MSB=1 selects global, MSB=0 selects local.
REQ-020 F-stage lookup SHALL be combinational from pcF and SHALL produce predL, predG and sel.
REQ-021 The F->D register {predL_r, predG_r, sel_r} SHALL clear to 0 on rst or flushD, with flushD having priority over stallD.
REQ-022 The F->D register SHALL hold when stallD=1 and SHALL load otherwise.
REQ-023 pred_globalD SHALL equal branchD & sel_r.
REQ-024 pred_takeD SHALL equal branchD & (sel_r ? predG_r : predL_r); latency from pcF to D output SHALL be 1 cycle.
REQ-025 When branchM=1, update indices SHALL be computed from pcM using pre-edge BHT and GHR values.
REQ-026 On update, the local PHT and global PHT counters SHALL each saturate toward actual_takeM (+1 taken, -1 not-taken, clamped at 00 and 11).
REQ-027 The choice counter SHALL update only when the pre-update local and global MSBs differ: +1 if global was correct, -1 if local was correct, saturating.
REQ-028 On update, BHT entry and GHR SHALL each shift left with actual_takeM inserted at bit 0.
REQ-029 All tables SHALL be written on the same edge; the written values SHALL be visible to F lookup from the next cycle.
REQ-030 When F lookup and M update hit the same entry in the same cycle, F SHALL observe the old value.
REQ-031 When branchM=0, no table or GHR SHALL change.
REQ-032 Parameter ranges SHALL be 1..29 for each parameter; the block SHALL have no other pc bits dependency.

Reset
REQ-033 On rst, all BHT entries and GHR SHALL become 0.
REQ-034 On rst, local and global PHT entries SHALL become 10 (WT) and choice entries SHALL become 01 (weak local).
REQ-035 On rst, the F->D register SHALL clear, so pred_takeD=0 and pred_globalD=0.
REQ-036 rst asserted mid-operation SHALL override simultaneous branchM/flushD/stallD.

Verification
REQ-037 Scenario: after reset, branchD=1, any pcF -> next cycle pred_takeD=1, pred_globalD=0; with branchD=0 -> pred_takeD=0.
REQ-038 Scenario: branchM=1, pcM=0x100, actual_takeM=0 once -> local[0] and global[0x40] become 01, choice unchanged, BHT[0x40]=0, GHR=0; pcF=0x100 next cycle -> pred_takeD=0.
REQ-039 Scenario: 3 taken updates at pcM=0x0 with GHR held by the pattern -> counter reaches 11; one not-taken -> 10, prediction still 1.
REQ-040 Scenario: stallD=1 with changing pcF -> pred_takeD held; flushD=1 together with stallD=1 -> pred_takeD=0 next cycle.
REQ-041 Scenario: a periodic T,N,T,N branch at one PC -> local and global disagree; the choice counter moves only on disagreement cycles, never beyond 00/11.
REQ-042 Scenario: assert rst after training -> all outputs and tables return to their REQ-033..REQ-035 values in one cycle.
